// File: rtl/gold_seq_gen.sv
// 3GPP gold sequence generator c(n): x1/x2 LFSRs, NC-step warm-up discard, valid/ready bit stream.
// Optional build macro GOLD_PAR8_WARMUP_EN: warm-up advances 8 LFSR steps per cycle (NC must be a multiple of 8).
module gold_seq_gen #(
    parameter int NC = 1600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [30:0] c_init,
    input  logic [10:0] seq_len,
    input  logic        out_ready,
    output logic        c_out,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

`ifdef GOLD_PAR8_WARMUP_EN
    localparam int WSTEPS = 8;
`else
    localparam int WSTEPS = 1;
`endif
    localparam int WCYC  = NC / WSTEPS;
    localparam int WLAST = (WCYC > 0) ? WCYC - 1 : 0;
    localparam int WW    = (WCYC > 1) ? $clog2(WCYC) : 1;

    generate
        if (NC % WSTEPS != 0) begin : g_nc_check
            $error("gold_seq_gen: NC must be a multiple of 8 when GOLD_PAR8_WARMUP_EN is defined");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WARMUP, STREAM, DONE} state_t;

    state_t          state;
    logic [30:0]     x1;
    logic [30:0]     x2;
    logic [10:0]     len_q;
    logic [10:0]     cnt;
    logic [WW-1:0]   warm_cnt;
    logic [30:0]     x1_warm;
    logic [30:0]     x2_warm;

    // Bit i of each register holds x(n+i); the new bit x(n+31) enters at the top.
    function automatic logic [30:0] x1_step(input logic [30:0] x);
        return {x[3] ^ x[0], x[30:1]};
    endfunction

    function automatic logic [30:0] x2_step(input logic [30:0] x);
        return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
    endfunction

    always_comb begin
        x1_warm = x1;
        x2_warm = x2;
        for (int i = 0; i < WSTEPS; i++) begin
            x1_warm = x1_step(x1_warm);
            x2_warm = x2_step(x2_warm);
        end
    end

    // c_out is registered, so every transition into or within STREAM preloads the bit that will be at position 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            x1        <= '0;
            x2        <= '0;
            len_q     <= '0;
            cnt       <= '0;
            warm_cnt  <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (seq_len != 11'd0) begin
                            x1       <= 31'h0000_0001;
                            x2       <= c_init;
                            len_q    <= seq_len;
                            cnt      <= '0;
                            warm_cnt <= '0;
                            if (WCYC == 0) begin
                                state     <= STREAM;
                                out_valid <= 1'b1;
                                c_out     <= c_init[0] ^ 1'b1;
                            end else begin
                                state <= WARMUP;
                            end
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                WARMUP: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        c_out     <= 1'b0;
                        done      <= 1'b0;
                    end else begin
                        x1 <= x1_warm;
                        x2 <= x2_warm;
                        if (warm_cnt == WW'(WLAST)) begin
                            state     <= STREAM;
                            out_valid <= 1'b1;
                            c_out     <= x1_warm[0] ^ x2_warm[0];
                        end else begin
                            warm_cnt <= warm_cnt + WW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        c_out     <= 1'b0;
                        done      <= 1'b0;
                    end else if (out_ready) begin
                        x1 <= x1_step(x1);
                        x2 <= x2_step(x2);
                        if (cnt == len_q - 11'd1) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            c_out     <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt   <= cnt + 11'd1;
                            c_out <= x1[1] ^ x2[1];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
